// File: rtl/decoder_scan_sequencer_if.sv
// Select-bus bundle between the scan sequencer and its controller/decoder.
// Latency: none, wires only.
// Backpressure: none; the consumer must accept every slot as it is presented.
interface decoder_scan_sequencer_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         skip_mask;
  logic               a;
  logic               b;
  logic               c;
  logic               sel_valid;
  logic               slot_done;
  logic               pass_done;
  logic               busy;

  modport master (
    output start, stop, mode, dwell, skip_mask,
    input  a, b, c, sel_valid, slot_done, pass_done, busy
  );

  modport slave (
    input  start, stop, mode, dwell, skip_mask,
    output a, b, c, sel_valid, slot_done, pass_done, busy
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Scans the 3x8 decoder select through unmasked slots 0..7, each held for a dwell time.
// Latency: first slot is presented the cycle after start is sampled; slots abut with no gaps.
// Backpressure: none; stop is honoured only at the end of the current slot.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst,
  decoder_scan_sequencer_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dlen;
  logic               mode_q;
  logic [7:0]         live;          // 1 = slot participates in the scan
  logic [2:0]         slot;
  logic               stop_pending;
  logic               sel_valid_q;
  logic               busy_q;
  logic               slot_done_q;
  logic               pass_done_q;

  // Lowest participating slot index.
  function automatic logic [2:0] first_live(input logic [7:0] m);
    first_live = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) first_live = 3'(i);
  endfunction

  // Lowest participating slot index strictly above cur.
  function automatic logic [2:0] next_live(input logic [7:0] m, input logic [2:0] cur);
    next_live = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_live = 3'(i);
  endfunction

  // Whether any participating slot lies above cur.
  function automatic logic live_above(input logic [7:0] m, input logic [2:0] cur);
    live_above = 1'b0;
    for (int i = 0; i < 8; i++)
      if (m[i] && (i > int'(cur))) live_above = 1'b1;
  endfunction

  logic [DWELL_W-1:0] d_in;
  logic [7:0]         l_live;
  logic [2:0]         l_first;
  logic               l_after;
  logic               launch;
  logic [DWELL_W-1:0] last_cnt;
  logic [DWELL_W-1:0] cnt_inc;
  logic               nxt_found;
  logic [2:0]         tgt;
  logic               tgt_after;
  logic               slot_end;
  logic               finish;

  // Launch-time and slot-boundary decode, all from latched state except the launch terms.
  always_comb begin
    d_in      = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    l_live    = ~bus.skip_mask;
    l_first   = first_live(l_live);
    l_after   = live_above(l_live, l_first);
    launch    = bus.start && !bus.stop && (bus.skip_mask != 8'hFF);
    last_cnt  = dlen - DWELL_W'(1);
    cnt_inc   = cnt + DWELL_W'(1);
    nxt_found = live_above(live, slot);
    tgt       = nxt_found ? next_live(live, slot) : first_live(live);
    tgt_after = live_above(live, tgt);
    slot_end  = (cnt == last_cnt);
    finish    = stop_pending || bus.stop || (!nxt_found && !mode_q);
  end

  // Scan FSM; every output is a register so status pulses line up with the held slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dlen         <= DWELL_W'(1);
      mode_q       <= 1'b0;
      live         <= 8'h00;
      slot         <= 3'd0;
      stop_pending <= 1'b0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      slot_done_q  <= 1'b0;
      pass_done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (launch) begin
            state       <= SCAN;
            dlen        <= d_in;
            mode_q      <= bus.mode;
            live        <= l_live;
            slot        <= l_first;
            cnt         <= '0;
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            slot_done_q <= (d_in == DWELL_W'(1));
            pass_done_q <= (d_in == DWELL_W'(1)) && !l_after;
          end
        end
        SCAN: begin
          if (slot_end) begin
            if (finish) begin
              state        <= IDLE;
              slot         <= 3'd0;
              cnt          <= '0;
              stop_pending <= 1'b0;
              sel_valid_q  <= 1'b0;
              busy_q       <= 1'b0;
              slot_done_q  <= 1'b0;
              pass_done_q  <= 1'b0;
            end else begin
              slot        <= tgt;
              cnt         <= '0;
              slot_done_q <= (dlen == DWELL_W'(1));
              pass_done_q <= (dlen == DWELL_W'(1)) && !tgt_after;
            end
          end else begin
            cnt          <= cnt_inc;
            stop_pending <= stop_pending || bus.stop;
            slot_done_q  <= (cnt_inc == last_cnt);
            pass_done_q  <= (cnt_inc == last_cnt) && !nxt_found;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = slot[2];
  assign bus.b         = slot[1];
  assign bus.c         = slot[0];
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.slot_done = slot_done_q;
  assign bus.pass_done = pass_done_q;

endmodule
